// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads, buffers returned instructions for decode.
// Optional misaligned-redirect fault handling is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   input  logic        inst_ready_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i
`ifdef FETCH_MISALIGN_CHECK_EN
   ,
   output logic        fault_o
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned SUM_W = CNT_W + 1;

   logic [31:0]      pc_q, pc_d;
   logic             req_q, req_d;
   logic [31:0]      addr_q, addr_d;
   logic             rsp_vld_q, rsp_vld_d;
   logic [31:0]      rsp_pc_q, rsp_pc_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [31:0]      inst_mem_q [DEPTH];
   logic [31:0]      pc_mem_q   [DEPTH];

   logic             push_c, pop_c, issue_c, run_c, wr_en_c;
   logic [SUM_W-1:0] occ_c;
   logic [31:0]      redir_pc_c;

`ifdef FETCH_MISALIGN_CHECK_EN
   typedef enum logic {ST_RUN = 1'b0, ST_FAULT = 1'b1} state_e;
   state_e state_q, state_d;
   logic   fault_q, fault_d;
   logic   misalign_c;

   assign misalign_c = |redirect_pc_i[1:0];

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_RUN;
      else       state_q <= state_d;
   end

   // FSM next state: every redirect re-decides between RUN and FAULT
   always_comb begin
      state_d = state_q;
      if (redirect_i) state_d = misalign_c ? ST_FAULT : ST_RUN;
   end

   // FSM outputs
   always_comb begin
      run_c   = 1'b0;
      fault_d = 1'b0;
      if (state_q == ST_RUN)  run_c   = 1'b1;
      if (state_d == ST_FAULT) fault_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) fault_q <= 1'b0;
      else       fault_q <= fault_d;
   end

   assign fault_o = fault_q;
`else
   logic unused_lsb_c;

   assign run_c        = 1'b1;
   assign unused_lsb_c = ^redirect_pc_i[1:0];
`endif

   assign redir_pc_c = {redirect_pc_i[31:2], 2'b00};
   assign push_c     = rsp_vld_q;
   assign pop_c      = valid_q && inst_ready_i;
   assign wr_en_c    = push_c && !redirect_i;
   // Credit check counts FIFO entries plus both in-flight slots; same-cycle pops are not credited
   assign occ_c      = SUM_W'(cnt_q) + SUM_W'(req_q) + SUM_W'(rsp_vld_q);
   assign issue_c    = run_c && (occ_c < SUM_W'(DEPTH));

   // Next-state for PC, request pipeline and FIFO bookkeeping; redirect overrides everything
   always_comb begin
      pc_d      = pc_q;
      req_d     = 1'b0;
      addr_d    = addr_q;
      rsp_vld_d = 1'b0;
      rsp_pc_d  = rsp_pc_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      if (redirect_i) begin
         pc_d     = redir_pc_c;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         rsp_vld_d = req_q;
         rsp_pc_d  = addr_q;
         if (issue_c) begin
            req_d  = 1'b1;
            addr_d = pc_q;
            pc_d   = pc_q + 32'd4;
         end
         if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
      end
      valid_d = (cnt_d != '0);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q      <= RESET_PC;
         req_q     <= 1'b0;
         addr_q    <= RESET_PC;
         rsp_vld_q <= 1'b0;
         rsp_pc_q  <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         valid_q   <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         rsp_vld_q <= rsp_vld_d;
         rsp_pc_q  <= rsp_pc_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         valid_q   <= valid_d;
      end
   end

   // FIFO storage; cleared on reset so the head reads zero
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            inst_mem_q[i] <= '0;
            pc_mem_q[i]   <= '0;
         end
      end else if (wr_en_c) begin
         inst_mem_q[wr_ptr_q] <= imem_rdata_i;
         pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
      end
   end

   assign imem_req_o   = req_q;
   assign imem_addr_o  = addr_q;
   assign inst_valid_o = valid_q;
   assign inst_o       = inst_mem_q[rd_ptr_q];
   assign inst_pc_o    = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random ready/redirect traffic, checked against
// an instruction-stream model (expected next PC, data = addr ^ 32'hA5A5_A5A5).
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

   logic        clk;
   logic        rst_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;
   logic        inst_ready_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        fault_o;
`endif

   fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_rdata_i (imem_rdata_i),
      .inst_valid_o (inst_valid_o),
      .inst_o       (inst_o),
      .inst_pc_o    (inst_pc_o),
      .inst_ready_i (inst_ready_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i)
`ifdef FETCH_MISALIGN_CHECK_EN
      ,
      .fault_o      (fault_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-cycle-latency memory: data for a sampled request is visible in the following cycle
   int req_cnt = 0;
   always @(posedge clk) begin
      if (imem_req_o) begin
         imem_rdata_i <= imem_addr_o ^ KEY;
         req_cnt      <= req_cnt + 1;
      end
   end

   int          checks = 0;
   int          errors = 0;
   int          n_acc  = 0;
   logic [31:0] exp_pc = RESET_PC;
   logic [31:0] acc_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; the stream model checks any transfer that happens on this edge
   task automatic tick();
      logic        acc, rst_s, redir_s;
      logic [31:0] pc_s, ins_s, rpc_s;
      acc     = inst_valid_o && inst_ready_i && !redirect_i && !rst_i;
      rst_s   = rst_i;
      redir_s = redirect_i;
      rpc_s   = redirect_pc_i;
      pc_s    = inst_pc_o;
      ins_s   = inst_o;
      @(posedge clk);
      #1;
      if (rst_s) begin
         exp_pc = RESET_PC;
      end else if (redir_s) begin
         exp_pc = {rpc_s[31:2], 2'b00};
         check("valid_after_redirect", 32'(inst_valid_o), 32'd0);
      end else if (acc) begin
         check("stream_pc", pc_s, exp_pc);
         check("stream_data", ins_s, exp_pc ^ KEY);
         acc_q.push_back(pc_s);
         n_acc++;
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   initial begin
      int base;
      rst_i         = 1'b1;
      inst_ready_i  = 1'b1;
      redirect_i    = 1'b0;
      redirect_pc_i = '0;
      tick();
      tick();
      check("rst_req",   32'(imem_req_o), 32'd0);
      check("rst_addr",  imem_addr_o, RESET_PC);
      check("rst_valid", 32'(inst_valid_o), 32'd0);
      check("rst_inst",  inst_o, 32'd0);
      check("rst_pc",    inst_pc_o, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
      check("rst_fault", 32'(fault_o), 32'd0);
`endif

      // Startup latency
      rst_i = 1'b0;
      tick();
      check("e1_req",   32'(imem_req_o), 32'd1);
      check("e1_addr",  imem_addr_o, RESET_PC);
      check("e1_valid", 32'(inst_valid_o), 32'd0);
      tick();
      check("e2_addr",  imem_addr_o, 32'h8000_0004);
      check("e2_valid", 32'(inst_valid_o), 32'd0);
      tick();
      check("e3_valid", 32'(inst_valid_o), 32'd1);
      check("e3_pc",    inst_pc_o, 32'h8000_0000);
      check("e3_inst",  inst_o, 32'h8000_0000 ^ KEY);
      tick();
      check("e4_pc", inst_pc_o, 32'h8000_0004);
      tick();
      check("e5_pc", inst_pc_o, 32'h8000_0008);

      // Backpressure from reset: exactly DEPTH requests, then issue stops
      rst_i = 1'b1;
      tick();
      rst_i        = 1'b0;
      inst_ready_i = 1'b0;
      base         = req_cnt;
      repeat (10) tick();
      check("bp_req_count", 32'(req_cnt - base), 32'(DEPTH));
      check("bp_req",   32'(imem_req_o), 32'd0);
      check("bp_valid", 32'(inst_valid_o), 32'd1);
      check("bp_pc",    inst_pc_o, 32'h8000_0000);
      check("bp_inst",  inst_o, 32'h8000_0000 ^ KEY);
      inst_ready_i = 1'b1;
      base         = n_acc;
      repeat (6) tick();
      check("drain_count", 32'(n_acc - base), 32'd6);
      check("drain_next",  exp_pc, 32'h8000_0018);

      // Redirect with reads in flight
      check("pre_redir_req", 32'(imem_req_o), 32'd1);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h8000_0100;
      tick();
      redirect_i = 1'b0;
      check("redir_req", 32'(imem_req_o), 32'd0);
      tick();
      check("redir_new_req",  32'(imem_req_o), 32'd1);
      check("redir_new_addr", imem_addr_o, 32'h8000_0100);
      tick();
      check("redir_e2_valid", 32'(inst_valid_o), 32'd0);
      tick();
      check("redir_e3_valid", 32'(inst_valid_o), 32'd1);
      check("redir_e3_pc",    inst_pc_o, 32'h8000_0100);
      tick();

      // PC wrap
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFF8;
      tick();
      redirect_i = 1'b0;
      acc_q.delete();
      repeat (8) tick();
      check("wrap_n", 32'(acc_q.size() >= 4), 32'd1);
      if (acc_q.size() >= 4) begin
         check("wrap_0", acc_q[0], 32'hFFFF_FFF8);
         check("wrap_1", acc_q[1], 32'hFFFF_FFFC);
         check("wrap_2", acc_q[2], 32'h0000_0000);
         check("wrap_3", acc_q[3], 32'h0000_0004);
      end

      // Reset pulse with a full FIFO
      inst_ready_i = 1'b0;
      repeat (8) tick();
      check("full_valid", 32'(inst_valid_o), 32'd1);
      check("full_req",   32'(imem_req_o), 32'd0);
      rst_i = 1'b1;
      tick();
      rst_i        = 1'b0;
      inst_ready_i = 1'b1;
      check("midrst_valid", 32'(inst_valid_o), 32'd0);
      check("midrst_req",   32'(imem_req_o), 32'd0);
      check("midrst_addr",  imem_addr_o, RESET_PC);
      repeat (3) tick();
      check("midrst_restart_valid", 32'(inst_valid_o), 32'd1);
      check("midrst_restart_pc",    inst_pc_o, RESET_PC);

      // Misaligned redirect
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h8000_0102;
      tick();
      redirect_i = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      repeat (4) tick();
      check("fault_set",   32'(fault_o), 32'd1);
      check("fault_req",   32'(imem_req_o), 32'd0);
      check("fault_valid", 32'(inst_valid_o), 32'd0);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h8000_0301;
      tick();
      redirect_i = 1'b0;
      tick();
      check("fault_stay", 32'(fault_o), 32'd1);
      check("fault_stay_req", 32'(imem_req_o), 32'd0);
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h8000_0200;
      tick();
      redirect_i = 1'b0;
      check("fault_clear", 32'(fault_o), 32'd0);
      repeat (3) tick();
      check("fault_resume_valid", 32'(inst_valid_o), 32'd1);
      check("fault_resume_pc",    inst_pc_o, 32'h8000_0200);
`else
      repeat (3) tick();
      check("misalign_valid", 32'(inst_valid_o), 32'd1);
      check("misalign_pc",    inst_pc_o, 32'h8000_0100);
`endif

      // Random ready and redirect traffic against the stream model
      base = n_acc;
      repeat (400) begin
         inst_ready_i = ($urandom_range(0, 9) < 7);
         redirect_i   = ($urandom_range(0, 19) == 0);
`ifdef FETCH_MISALIGN_CHECK_EN
         redirect_pc_i = $urandom & 32'hFFFF_FFFC;
`else
         redirect_pc_i = $urandom;
`endif
         tick();
      end
      redirect_i = 1'b0;
      check("random_progress", 32'((n_acc - base) >= 100), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
